// File: rtl/cv32e40p_popcnt_tmr_pipe.sv
// cv32e40p_popcnt_tmr_pipe: two-stage, triple-redundant population counter.
// The replica results are majority voted, and replica faults are reported.
//
// Parameters:
//   LEN   - operand width in bits (>= 2)
//   CNT_W - error counter width
//   RES_W - result width, $clog2(LEN+1) (localparam)
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   valid_i       in   operand valid
//   ready_o       out  block can accept an operand
//   in_i          in   operand [LEN-1:0]
//   valid_o       out  result valid
//   ready_i       in   downstream accepts the result
//   result_o      out  voted popcount [RES_W-1:0]
//   err_o         out  corrected error on this beat (exactly two replicas agree)
//   fatal_o       out  uncorrectable beat (no two replicas agree)
//   err_replica_o out  sticky per-replica disagreement flags [2:0]
//   clear_i       in   clears err_replica_o and err_cnt_o
//   err_cnt_o     out  saturating count of erroneous accepted beats [CNT_W-1:0]
//
// Build option: define CV32E40P_POPCNT_TMR_ERR_CNT_EN to implement the
// error counter. Without it, err_cnt_o is tied to zero and has no flops.

module cv32e40p_popcnt_tmr_pipe_rep #(
    parameter int unsigned LEN   = 32,
    parameter int unsigned RES_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld1,
    input  logic             i_ld2,
    input  logic [LEN-1:0]   i_op,
    output logic [RES_W-1:0] o_res
);

    logic [LEN-1:0]   r_op;
    logic [RES_W-1:0] r_res;
    logic [RES_W-1:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < LEN; i++) begin
            w_cnt = w_cnt + RES_W'(r_op[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= '0;
        end else if (i_ld1) begin
            r_op <= i_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (i_ld2) begin
            r_res <= w_cnt;
        end
    end

    assign o_res = r_res;

endmodule

module cv32e40p_popcnt_tmr_pipe #(
    parameter int unsigned LEN   = 32,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned RES_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [LEN-1:0]   in_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [RES_W-1:0] result_o,
    output logic             err_o,
    output logic             fatal_o,
    output logic [2:0]       err_replica_o,
    input  logic             clear_i,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic             r_v1;
    logic             r_v2;
    logic             w_en1;
    logic             w_en2;
    logic             w_ld1;
    logic [RES_W-1:0] w_res0;
    logic [RES_W-1:0] w_res1;
    logic [RES_W-1:0] w_res2;
    logic             w_a01;
    logic             w_a02;
    logic             w_a12;
    logic             w_all;
    logic             w_any;
    logic             w_err;
    logic             w_fatal;
    logic [2:0]       w_bad;
    logic             w_acc;
    logic [2:0]       r_err_rep;

    // A stage may advance when it is empty or its successor advances.
    assign w_en2   = ~r_v2 | ready_i;
    assign w_en1   = ~r_v1 | w_en2;
    assign w_ld1   = valid_i & w_en1;
    assign ready_o = w_en1;
    assign valid_o = r_v2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
        end else if (w_en1) begin
            r_v1 <= valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2 <= 1'b0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
        end
    end

    // Each replica owns its operand and result registers so a single upset
    // cannot reach more than one of them; keep them through synthesis.
    (* dont_touch = "true" *)
    cv32e40p_popcnt_tmr_pipe_rep #(
        .LEN   (LEN),
        .RES_W (RES_W)
    ) u_rep0 (
        .clk   (clk),
        .rst   (rst),
        .i_ld1 (w_ld1),
        .i_ld2 (w_en2),
        .i_op  (in_i),
        .o_res (w_res0)
    );

    (* dont_touch = "true" *)
    cv32e40p_popcnt_tmr_pipe_rep #(
        .LEN   (LEN),
        .RES_W (RES_W)
    ) u_rep1 (
        .clk   (clk),
        .rst   (rst),
        .i_ld1 (w_ld1),
        .i_ld2 (w_en2),
        .i_op  (in_i),
        .o_res (w_res1)
    );

    (* dont_touch = "true" *)
    cv32e40p_popcnt_tmr_pipe_rep #(
        .LEN   (LEN),
        .RES_W (RES_W)
    ) u_rep2 (
        .clk   (clk),
        .rst   (rst),
        .i_ld1 (w_ld1),
        .i_ld2 (w_en2),
        .i_op  (in_i),
        .o_res (w_res2)
    );

    // Bitwise vote; with no agreeing pair this is still the output value.
    assign result_o = (w_res0 & w_res1)
                    | (w_res0 & w_res2)
                    | (w_res1 & w_res2);

    assign w_a01 = (w_res0 == w_res1);
    assign w_a02 = (w_res0 == w_res2);
    assign w_a12 = (w_res1 == w_res2);
    assign w_all = w_a01 & w_a02;
    assign w_any = w_a01 | w_a02 | w_a12;

    assign w_err   = r_v2 & ~w_all & w_any;
    assign w_fatal = r_v2 & ~w_any;
    assign err_o   = w_err;
    assign fatal_o = w_fatal;

    // Odd one out is the replica outside the agreeing pair.
    always_comb begin
        w_bad = 3'b000;
        if (w_fatal) begin
            w_bad = 3'b111;
        end else if (w_err) begin
            w_bad[0] = w_a12 & ~w_a01;
            w_bad[1] = w_a02 & ~w_a01;
            w_bad[2] = w_a01 & ~w_a02;
        end
    end

    assign w_acc = r_v2 & ready_i;

    // A flag raised in the clearing cycle survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_rep <= 3'b000;
        end else begin
            r_err_rep <= (clear_i ? 3'b000 : r_err_rep)
                       | (w_acc ? w_bad : 3'b000);
        end
    end

    assign err_replica_o = r_err_rep;

`ifdef CV32E40P_POPCNT_TMR_ERR_CNT_EN
    logic             w_hit;
    logic [CNT_W-1:0] r_cnt;

    assign w_hit = w_acc & (w_err | w_fatal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign err_cnt_o = r_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_popcnt_tmr_pipe.sv
// tb_cv32e40p_popcnt_tmr_pipe: self-checking bench for the TMR popcount
// pipeline; table vectors, scoreboard, fault forcing and corner sequences.

module tb_cv32e40p_popcnt_tmr_pipe;

    localparam int LEN   = 32;
    localparam int CNT_W = 8;
    localparam int RES_W = 6;

`ifdef CV32E40P_POPCNT_TMR_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             valid_i;
    logic             ready_o;
    logic [LEN-1:0]   in_i;
    logic             valid_o;
    logic             ready_i;
    logic [RES_W-1:0] result_o;
    logic             err_o;
    logic             fatal_o;
    logic [2:0]       err_replica_o;
    logic             clear_i;
    logic [CNT_W-1:0] err_cnt_o;

    cv32e40p_popcnt_tmr_pipe #(
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .in_i          (in_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .result_o      (result_o),
        .err_o         (err_o),
        .fatal_o       (fatal_o),
        .err_replica_o (err_replica_o),
        .clear_i       (clear_i),
        .err_cnt_o     (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LEN-1:0] op;
        int             res;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int q[$];
    int tb_exp = 0;
    bit sb_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accepted operand, pop on accepted result.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (valid_i && ready_o) begin
                q.push_back(tb_exp);
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_beat", 1, 0);
                end else begin
                    chk("sb_result", int'(result_o), q.pop_front());
                    chk("sb_err", int'(err_o), 0);
                    chk("sb_fatal", int'(fatal_o), 0);
                end
            end
        end
    end

    task automatic drain(input string name);
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            step();
        end
        chk(name, q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'h0000_0000, 0};
        vecs[1] = '{32'hFFFF_FFFF, 32};
        vecs[2] = '{32'h8000_0001, 2};
        vecs[3] = '{32'h0000_FFFF, 16};
        vecs[4] = '{32'hAAAA_AAAA, 16};
        vecs[5] = '{32'h0000_0001, 1};
        vecs[6] = '{32'h7FFF_FFFF, 31};
        vecs[7] = '{32'h1234_5678, 13};
        vecs[8] = '{32'hF0F0_F0F0, 16};
        vecs[9] = '{32'h0000_00FF, 8};

        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        in_i    = '0;
        clear_i = 1'b0;
        #1;
        chk("rst_ready_o", int'(ready_o), 1);
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_result", int'(result_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_fatal", int'(fatal_o), 0);
        chk("rst_err_rep", int'(err_replica_o), 0);
        chk("rst_err_cnt", int'(err_cnt_o), 0);
        step();
        step();
        rst     = 1'b0;
        ready_i = 1'b1;
        sb_en   = 1'b1;
        step();

        // Streamed table vectors with latency check on the first beats.
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1;
            in_i    = vecs[i].op;
            tb_exp  = vecs[i].res;
            step();
            if (i == 0) chk("lat_edge1_valid", int'(valid_o), 0);
            if (i == 1) chk("lat_edge2_valid", int'(valid_o), 1);
            if (i == 1) chk("lat_edge2_result", int'(result_o), 0);
        end
        valid_i = 1'b0;
        drain("stream_drain");

        // Single replica fault: corrected.
        sb_en = 1'b0;
        force dut.w_res1 = 6'd5;
        valid_i = 1'b1;
        in_i    = 32'h0000_00FF;
        step();
        valid_i = 1'b0;
        step();
        chk("err1_valid", int'(valid_o), 1);
        chk("err1_result", int'(result_o), 8);
        chk("err1_err", int'(err_o), 1);
        chk("err1_fatal", int'(fatal_o), 0);
        step();
        chk("err1_rep", int'(err_replica_o), 3'b010);
        chk("err1_cnt", int'(err_cnt_o), CNT_EN ? 1 : 0);
        release dut.w_res1;

        // Clear alone, then all replicas disagree.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr1_rep", int'(err_replica_o), 0);
        chk("clr1_cnt", int'(err_cnt_o), 0);
        force dut.w_res0 = 6'd1;
        force dut.w_res1 = 6'd2;
        force dut.w_res2 = 6'd4;
        valid_i = 1'b1;
        in_i    = 32'h0000_0003;
        step();
        valid_i = 1'b0;
        step();
        chk("fat_fatal", int'(fatal_o), 1);
        chk("fat_err", int'(err_o), 0);
        chk("fat_result", int'(result_o), 0);
        step();
        chk("fat_rep", int'(err_replica_o), 3'b111);
        chk("fat_cnt", int'(err_cnt_o), CNT_EN ? 1 : 0);
        release dut.w_res0;
        release dut.w_res1;
        release dut.w_res2;
        step();

        // Backpressure: three operands, five stalled cycles.
        sb_en   = 1'b1;
        ready_i = 1'b0;
        valid_i = 1'b1;
        in_i    = 32'h0000_000F;
        tb_exp  = 4;
        step();
        chk("stall_ready_a", int'(ready_o), 1);
        in_i   = 32'h0000_0007;
        tb_exp = 3;
        step();
        chk("stall_ready_b", int'(ready_o), 0);
        chk("stall_valid", int'(valid_o), 1);
        chk("stall_result_b", int'(result_o), 4);
        in_i   = 32'h00FF_00FF;
        tb_exp = 16;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold_ready", int'(ready_o), 0);
            chk("stall_hold_result", int'(result_o), 4);
        end
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        drain("stall_drain");

        // Saturation with a stuck replica.
        sb_en   = 1'b0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        force dut.w_res1 = 6'd63;
        valid_i = 1'b1;
        in_i    = '0;
        for (int k = 0; k < 300; k++) begin
            step();
        end
        valid_i = 1'b0;
        step();
        step();
        step();
        chk("sat_cnt", int'(err_cnt_o), CNT_EN ? 255 : 0);
        chk("sat_rep", int'(err_replica_o), 3'b010);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr2_cnt", int'(err_cnt_o), 0);
        chk("clr2_rep", int'(err_replica_o), 0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        chk("clr3_err", int'(err_o), 1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr3_cnt", int'(err_cnt_o), CNT_EN ? 1 : 0);
        chk("clr3_rep", int'(err_replica_o), 3'b010);
        release dut.w_res1;
        step();

        // Asynchronous reset with both stages full.
        valid_i = 1'b1;
        in_i    = 32'h0000_000F;
        step();
        in_i = 32'h0000_00FF;
        step();
        chk("mid_valid_pre", int'(valid_o), 1);
        rst = 1'b1;
        #1;
        chk("mid_valid", int'(valid_o), 0);
        chk("mid_result", int'(result_o), 0);
        chk("mid_err", int'(err_o), 0);
        chk("mid_fatal", int'(fatal_o), 0);
        chk("mid_rep", int'(err_replica_o), 0);
        chk("mid_cnt", int'(err_cnt_o), 0);
        chk("mid_ready", int'(ready_o), 1);
        valid_i = 1'b0;
        step();
        rst = 1'b0;
        q.delete();
        step();
        chk("post_valid_idle", int'(valid_o), 0);
        sb_en   = 1'b1;
        valid_i = 1'b1;
        in_i    = 32'h0000_0003;
        tb_exp  = 2;
        step();
        valid_i = 1'b0;
        chk("post_lat1", int'(valid_o), 0);
        step();
        chk("post_lat2", int'(valid_o), 1);
        chk("post_result", int'(result_o), 2);
        drain("post_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40p_popcnt_tmr_pipe.md
# cv32e40p_popcnt_tmr_pipe

Parametrised, pipelined, triple-modular-redundant population counter with valid/ready handshake, registered replica results, word-level majority voting and error reporting. It is the next-generation replacement for the combinational fault-tolerant popcount used by the ALU bit-manipulation path. It adds:
- arbitrary operand width
- flow control
- per-replica fault attribution
- an optional saturating error counter for the FT monitor

## Interface
Parameters:
- LEN, 32, operand width in bits (≥2).
- CNT_W, 8, error counter width.
- RES_W (localparam), $clog2(LEN+1), result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  operand valid.
- ready_o  out  1  block can accept operand.
- in_i  in  LEN  operand.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- result_o  out  RES_W  voted popcount of in_i.
- err_o  out  1  corrected error on current output beat (exactly two replicas agree).
- fatal_o  out  1  uncorrectable on current beat (no two replicas agree).
- err_replica_o  out  3  sticky: bit k set when replica k disagreed on an accepted beat.
- clear_i  in  1  clears err_replica_o and err_cnt_o.
- err_cnt_o  out  CNT_W  saturating count of accepted beats with err_o or fatal_o.

## Operation
- Stage 1 (S1): three independent operand registers in_r[0..2], each loaded from in_i, plus valid flag v1.
- Stage 2 (S2):
  - Replica k computes the popcount of in_r[k] into res_r[k] (RES_W bits); valid flag v2.
  - Each replica's logic and register is separate; synthesis must keep them (dont_touch on the replica instances).
- Voter (combinational, on res_r):
  - result_o: bitwise 2-of-3 majority of res_r[0..2].
  - Word agreement: a_kj = (res_r[k] == res_r[j]).
  - err_o = valid_o & not all three equal & at least one a_kj.
  - fatal_o = valid_o & no a_kj true. result_o is still the bitwise majority in this case.
  - Disagreeing replica (for err_o): the one not in the agreeing pair. All three are flagged when fatal_o.
- Sticky and counter updates, on accepted beats (valid_o & ready_i):
  - err_replica_o bits for the disagreeing replicas are set.
  - err_cnt_o increments by 1 if err_o|fatal_o; it saturates at 2^CNT_W−1.
- clear_i:
  - Zeroes err_replica_o and err_cnt_o.
  - If an accepted erroneous beat occurs in the same cycle, the set/increment wins: register value = that beat's flags, count = 1.
- Flow control:
  - en2 = ~v2 | ready_i.
  - en1 = ~v1 | en2.
  - ready_o = en1.
  - S1 loads on valid_i & en1. v1 ← valid_i when en1.
  - S2 loads on en2. v2 ← v1 when en2.
- Reset value of every output: ready_o=1 (combinational from cleared valids), valid_o=0, result_o=0, err_o=0, fatal_o=0, err_replica_o=0, err_cnt_o=0. All registers clear.

## Timing
- Latency: operand accepted at edge n → valid_o high after edge n+1 (2 register stages). Throughput 1 beat/cycle with ready_i held high.
- Stall (ready_i=0 with v2=1):
  - result_o, err_o, fatal_o are held stable.
  - S1 may still fill if empty. ready_o drops once S1 and S2 are both full.
  - No beat is dropped or duplicated.
- valid_o must not depend combinationally on ready_i. ready_o may depend combinationally on ready_i.
- Flags are registered-path combinational from res_r and change only when S2 loads.
- Asynchronous reset mid-operation: in-flight beats are discarded immediately, and outputs take reset values within the reset-assert cycle.
- LEN=2^m−1 boundary: all-ones operand yields LEN without overflow of RES_W. LEN=32 yields RES_W=6.

## Configuration
- Macro CV32E40P_POPCNT_TMR_ERR_CNT_EN.
- Defined: the err_cnt_o counter is implemented as above.
- Undefined: no counter flops; err_cnt_o tied to 0. err_replica_o and clear_i keep full function. Ports are unchanged.

## Test plan
- Reset, then stream in_i=32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001 with ready_i=1 → valid_o on cycles 2,3,4 with result_o=0, 32, 2; err_o=fatal_o=0.
- Force res_r[1]=6'd5 while in_i=32'h0000_00FF → result_o=8, err_o=1, fatal_o=0, err_replica_o=3'b010, err_cnt_o=1 (macro defined) / 0 (undefined).
- Force res_r[0]=1, res_r[1]=2, res_r[2]=4 → fatal_o=1, result_o=0 (bitwise majority), err_replica_o=3'b111.
- Hold ready_i=0 for 5 cycles while valid_i=1 with 3 distinct operands → ready_o low after 2 accepts; on release the results emerge in order, none lost.
- Inject 300 errors with CNT_W=8 → err_cnt_o saturates at 255. Pulse clear_i alone → 0. Pulse clear_i together with an erroneous accepted beat → 1.
- Assert rst mid-stream with v1=v2=1 → valid_o=0 and all flags 0 immediately. After release, first new operand appears 2 cycles after acceptance.
